// File: rtl/spigot_pkg.sv
// rtl/spigot_pkg.sv - shared types and ASCII constants for the spigot digit transmitter
package spigot_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
   typedef enum logic [1:0] {INS_NONE, INS_DOT, INS_CR, INS_LF} ins_t;
   typedef logic [3:0] digit_t;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_DOT  = 8'h2E;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_ERR  = 8'h3F;

   function automatic logic [7:0] digit_to_ascii(input digit_t d);
      return (d <= 4'd9) ? ASCII_ZERO + {4'h0, d} : ASCII_ERR;
   endfunction

endpackage

// File: rtl/spigot_digit_fifo.sv
// rtl/spigot_digit_fifo.sv - small digit FIFO, head word readable combinationally
module spigot_digit_fifo
   import spigot_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  digit_t        din,
   input  logic          pop,
   input  logic          flush,
   output digit_t        dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   digit_t        mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/spigot_digit_tx.sv
// rtl/spigot_digit_tx.sv - buffers spigot digits and sends them as formatted ASCII over UART 8N1
module spigot_digit_tx
   import spigot_pkg::*;
#(
   parameter  int CLK_DIV    = 4,
   parameter  int FIFO_DEPTH = 8,
   parameter  int LINE_LEN   = 4,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ena,
   input  logic          clear,
   input  logic          digit_valid,
   input  logic [3:0]    digit,
   output logic          digit_ready,
   output logic          tx,
   output logic          busy,
   output logic          err,
   output logic [LW-1:0] fifo_level
);

   localparam int TW = $clog2(CLK_DIV);
   localparam int CW = $clog2(LINE_LEN + 1);

   tx_state_t     state, state_nx;
   ins_t          ins;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [7:0]    next_char;
   logic [CW-1:0] line_cnt;
   logic          tx_q, active_q, err_q, clear_pending, first_digit;
   logic          tick, can_launch, launch, do_flush, pop;
   logic          fifo_full, fifo_empty;
   digit_t        head;

   spigot_digit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (digit_valid && digit_ready),
      .din   (digit),
      .pop   (pop),
      .flush (do_flush),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign digit_ready = !fifo_full && !clear_pending;
   assign tx          = tx_q;
   assign err         = err_q;
   // active_q keeps busy high through the last stop bit, which tx emits one cycle late
   assign busy        = active_q || (state != IDLE) || !fifo_empty || (ins != INS_NONE);
   assign tick        = (timer == TW'(CLK_DIV - 1));
   assign can_launch  = ena && !clear_pending && ((ins != INS_NONE) || !fifo_empty);
   assign pop         = launch && (ins == INS_NONE);

   always_comb begin
      case (ins)
         INS_DOT: next_char = ASCII_DOT;
         INS_CR:  next_char = ASCII_CR;
         INS_LF:  next_char = ASCII_LF;
         default: next_char = digit_to_ascii(head);
      endcase
   end

   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      do_flush = 1'b0;
      case (state)
         IDLE: begin
            if (clear_pending) begin
               do_flush = 1'b1;
            end else if (can_launch) begin
               launch   = 1'b1;
               state_nx = START;
            end
         end
         START: if (tick) state_nx = DATA;
         DATA:  if (tick && bit_idx == 3'd7) state_nx = STOP;
         STOP: begin
            // a pending clear replaces the next character, never the current frame
            if (tick) begin
               state_nx = IDLE;
               if (clear_pending) begin
                  do_flush = 1'b1;
               end else if (can_launch) begin
                  launch   = 1'b1;
                  state_nx = START;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         ins           <= INS_NONE;
         timer         <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         line_cnt      <= '0;
         tx_q          <= 1'b1;
         active_q      <= 1'b0;
         err_q         <= 1'b0;
         clear_pending <= 1'b0;
         first_digit   <= 1'b1;
      end else begin
         state         <= state_nx;
         active_q      <= (state != IDLE);
         clear_pending <= clear | (clear_pending & ~do_flush);
         timer         <= (state == IDLE || tick) ? '0 : timer + 1'b1;
         if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
         case (state)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= shreg[bit_idx];
            default: tx_q <= 1'b1;
         endcase
         if (do_flush) begin
            ins         <= INS_NONE;
            line_cnt    <= '0;
            first_digit <= 1'b1;
         end else if (launch) begin
            shreg <= next_char;
            case (ins)
               INS_CR:  ins <= INS_LF;
               INS_DOT,
               INS_LF:  ins <= INS_NONE;
               default: begin
                  if (head > 4'd9) err_q <= 1'b1;
                  if (first_digit) begin
                     first_digit <= 1'b0;
                     ins         <= INS_DOT;
                  end else if (line_cnt == CW'(LINE_LEN - 1)) begin
                     line_cnt <= '0;
                     ins      <= INS_CR;
                  end else begin
                     line_cnt <= line_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spigot_digit_tx.sv
// tb/tb_spigot_digit_tx.sv - self-checking bench for spigot_digit_tx
module tb_spigot_digit_tx;

   localparam int CD    = 4;
   localparam int DEPTH = 8;
   localparam int LL    = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b1;
   logic          clear = 1'b0;
   logic          digit_valid = 1'b0;
   logic [3:0]    digit = 4'h0;
   logic          digit_ready, tx, busy, err;
   logic [LW-1:0] fifo_level;

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            n_acc = 0;
   int            busy_fall = 0;
   int            acc_cyc = 0;
   int            m_cnt = 0;
   bit            m_first = 1'b1;
   bit            drv_done = 1'b0;
   logic [7:0]    exp_q[$];
   logic [7:0]    rx_log[$];
   int            start_log[$];
   logic [7:0]    mon_ch, mon_rx;
   logic          mon_bit;
   bit            mon_has;

   spigot_digit_tx #(.CLK_DIV(CD), .FIFO_DEPTH(DEPTH), .LINE_LEN(LL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .clear       (clear),
      .digit_valid (digit_valid),
      .digit       (digit),
      .digit_ready (digit_ready),
      .tx          (tx),
      .busy        (busy),
      .err         (err),
      .fifo_level  (fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      rx_log.delete();
      start_log.delete();
      m_first = 1'b1;
      m_cnt   = 0;
   endtask

   task automatic model_accept(input logic [3:0] d);
      exp_q.push_back((d <= 4'd9) ? 8'h30 + {4'h0, d} : 8'h3F);
      n_acc++;
      if (m_first) begin
         exp_q.push_back(8'h2E);
         m_first = 1'b0;
      end else begin
         m_cnt++;
         if (m_cnt == LL) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
            m_cnt = 0;
         end
      end
   endtask

   // called at a falling edge; returns at the falling edge after the accepting edge
   task automatic push_digit(input logic [3:0] d);
      int w = 0;
      digit_valid = 1'b1;
      digit = d;
      while (digit_ready !== 1'b1 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      check("push_ready_timeout", digit_ready, 1'b1);
      if (digit_ready === 1'b1) model_accept(d);
      @(negedge clk);
      digit_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int w = 0;
      while (busy !== 1'b0 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      busy_fall = cyc;
      check({name, "_idle"}, busy, 1'b0);
      check({name, "_all_chars_sent"}, exp_q.size(), 0);
   endtask

   task automatic wait_frames(input int n);
      int w = 0;
      while (start_log.size() < n && w < 3000) begin
         @(negedge clk);
         w++;
      end
      check("frame_start_timeout", start_log.size() >= n, 1'b1);
   endtask

   task automatic wait_cycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ena = 1'b1;
      clear = 1'b0;
      digit_valid = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // UART monitor: every cycle of every frame is compared against the next expected character
   always begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
         start_log.push_back(cyc);
         mon_has = (exp_q.size() > 0);
         mon_ch  = mon_has ? exp_q.pop_front() : 8'h00;
         mon_rx  = 8'h00;
         if (!mon_has) check("unexpected_frame", 1'b1, 1'b0);
         for (int i = 0; i < 10 * CD; i++) begin
            if (i > 0) @(negedge clk);
            if (rst_n !== 1'b1) break;
            if (i < CD)          mon_bit = 1'b0;
            else if (i < 9 * CD) mon_bit = mon_ch[(i - CD) / CD];
            else                 mon_bit = 1'b1;
            if (mon_has) check("tx_bit", tx, mon_bit);
            if (i >= CD && i < 9 * CD && ((i - CD) % CD) == CD / 2) mon_rx[(i - CD) / CD] = tx;
         end
         if (rst_n === 1'b1) rx_log.push_back(mon_rx);
      end
   end

   initial begin
      logic [7:0] t1 [4];
      logic [7:0] t2 [9];
      logic [3:0] d3 [12];
      t1 = '{8'h33, 8'h2E, 8'h31, 8'h34};
      t2 = '{8'h33, 8'h2E, 8'h31, 8'h34, 8'h31, 8'h35, 8'h0D, 8'h0A, 8'h39};
      d3 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd2, 4'd7};

      // reset state
      do_reset();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_level", fifo_level, 0);
      check("rst_ready", digit_ready, 1'b1);

      // 3,1,4: latency, contiguous frames, simultaneous push/pop, busy fall
      acc_cyc = cyc;
      push_digit(4'd3);
      check("level_after_first_push", fifo_level, 1);
      push_digit(4'd1);
      check("level_push_and_pop", fifo_level, 1);
      push_digit(4'd4);
      check("level_two_queued", fifo_level, 2);
      wait_idle("t1");
      check("t1_frames", start_log.size(), 4);
      check("t1_latency", start_log[0] - acc_cyc, 3);
      for (int i = 1; i < 4; i++) check("t1_frame_spacing", start_log[i] - start_log[i-1], 10 * CD);
      for (int i = 0; i < 4; i++) check("t1_char", rx_log[i], t1[i]);
      check("t1_busy_fall", busy_fall - start_log[3], 10 * CD);

      // 3,1,4,1,5,9: CR LF after the fourth fractional digit
      do_reset();
      push_digit(4'd3); push_digit(4'd1); push_digit(4'd4);
      push_digit(4'd1); push_digit(4'd5); push_digit(4'd9);
      wait_idle("t2");
      check("t2_len", rx_log.size(), 9);
      for (int i = 0; i < 9; i++) check("t2_char", rx_log[i], t2[i]);

      // ena low: FIFO fills to 8 and stalls, then drains in order
      do_reset();
      ena = 1'b0;
      n_acc = 0;
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 12; i++) push_digit(d3[i]);
            drv_done = 1'b1;
         end
      join_none
      repeat (30) @(negedge clk);
      check("t3_accepted", n_acc, 8);
      check("t3_ready_full", digit_ready, 1'b0);
      check("t3_level_full", fifo_level, 8);
      check("t3_tx_idle", tx, 1'b1);
      check("t3_no_frames", start_log.size(), 0);
      ena = 1'b1;
      @(negedge clk);
      check("t3_ready_after_pop", digit_ready, 1'b1);
      for (int w = 0; w < 3000 && !drv_done; w++) @(negedge clk);
      check("t3_driver_done", drv_done, 1'b1);
      wait_idle("t3");
      check("t3_accepted_all", n_acc, 12);
      check("t3_len", rx_log.size(), 17);

      // illegal digit -> '?' and sticky err
      do_reset();
      push_digit(4'd5);
      wait_idle("t4a");
      check("t4_err_clean", err, 1'b0);
      push_digit(4'hC);
      push_digit(4'd6);
      wait_idle("t4b");
      check("t4_err_set", err, 1'b1);
      check("t4_qmark", rx_log[2], 8'h3F);
      push_digit(4'd7);
      wait_idle("t4c");
      check("t4_err_sticky", err, 1'b1);
      do_reset();
      check("t4_err_cleared", err, 1'b0);

      // clear in the middle of the '.' frame with three digits queued
      push_digit(4'd7);
      wait_frames(1);
      push_digit(4'd1); push_digit(4'd2); push_digit(4'd3);
      check("t5_queued", fifo_level, 3);
      wait_frames(2);
      wait_cycle(start_log[1] + 15);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      exp_q.delete();
      m_first = 1'b1;
      m_cnt = 0;
      check("t5_ready_pending", digit_ready, 1'b0);
      wait_idle("t5a");
      check("t5_level_flushed", fifo_level, 0);
      check("t5_ready_back", digit_ready, 1'b1);
      check("t5_frames", start_log.size(), 2);
      check("t5_dot_intact", rx_log[1], 8'h2E);
      push_digit(4'd2);
      wait_idle("t5b");
      check("t5_after_digit", rx_log[2], 8'h32);
      check("t5_after_dot", rx_log[3], 8'h2E);

      // async reset mid-DATA
      do_reset();
      push_digit(4'hC); push_digit(4'd1); push_digit(4'd2);
      wait_frames(1);
      wait_cycle(start_log[0] + 29);
      #2;
      check("t6_tx_low_before", tx, 1'b0);
      check("t6_err_before", err, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_tx_async", tx, 1'b1);
      check("t6_level_async", fifo_level, 0);
      check("t6_err_async", err, 1'b0);
      @(negedge clk);
      #2;
      model_reset();
      rst_n = 1'b1;
      @(negedge clk);
      push_digit(4'd4);
      push_digit(4'd5);
      wait_idle("t6");
      check("t6_len", rx_log.size(), 3);
      check("t6_c0", rx_log[0], 8'h34);
      check("t6_c1", rx_log[1], 8'h2E);
      check("t6_c2", rx_log[2], 8'h35);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spigot_digit_tx.md
Name: spigot_digit_tx

Overview:
- Output end of the spigot digit stream: consumes 4-bit decimal digits from the spigot engine over a valid/ready handshake and buffers them in a small FIFO.
- Formats the digits as ASCII text ("3.1415…", with CR LF line breaks) and transmits it as UART 8N1 on a single pin.
- Sits between the spigot core and the top-level output pins; tx drives one uo_out bit at the top level.

Parameters:
CLK_DIV, 4, clock cycles per UART bit (>=2)
FIFO_DEPTH, 8, digit FIFO entries (power of 2, >=2)
LINE_LEN, 4, fractional digits per line before CR LF (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  enable; when low, no new character starts (the current one completes), and digit_ready is still driven by FIFO state
clear  input  1  single-cycle restart request
digit_valid  input  1  digit available from spigot core
digit  input  4  BCD digit, 0..9 legal
digit_ready  output  1  FIFO can accept (= not full, and no clear pending)
tx  output  1  UART line, idle high
busy  output  1  character in flight or FIFO non-empty
err  output  1  sticky: illegal digit (10..15) seen
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): tx=1, busy=0, err=0, fifo_level=0, digit_ready=1, FIFO empty, line counter=0, first_digit flag=1, FSM=IDLE.
- Handshake:
  - A digit is accepted on an edge where digit_valid&&digit_ready; fifo_level increments the following cycle.
  - digit must hold stable while valid&&!ready.
  - Full FIFO: digit_ready=0 and nothing is accepted.
- Character sequencer, one character per UART frame:
  - First digit after reset/clear: send ASCII digit, then '.' (0x2E); clear first_digit.
  - Later digits: send ASCII digit and increment the line counter. When the counter reaches LINE_LEN, send CR (0x0D) then LF (0x0A), then reset the counter to 0.
  - Legal digit d is sent as 0x30+d. Illegal digits are sent as '?' (0x3F) and set err (cleared only by reset).
  - Inserted characters ('.', CR, LF) need no FIFO data and are never skipped.
- TX FSM: IDLE -> START -> DATA -> STOP -> (next char? START : IDLE).
  - IDLE -> START when ena=1 and either an inserted char is pending or the FIFO is non-empty. The FIFO is popped on the same edge.
  - START: tx=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: tx=1 for CLK_DIV cycles.
  - Back-to-back characters: the next start bit follows the stop bit with no gap. Frame = 10*CLK_DIV cycles.
  - tx is registered.
- Latency: with FIFO empty and FSM IDLE, tx goes low on the 2nd rising edge after the accepting edge.
- Bit timer: counts 0..CLK_DIV-1 and wraps; bit index counts 0..7.
- clear:
  - Sets clear_pending; digit_ready=0 while pending.
  - If IDLE, it takes effect next edge: FIFO flushed, line counter=0, first_digit=1, pending inserted chars dropped.
  - If mid-frame, the current frame completes (tx waveform is never truncated), then the flush occurs instead of starting a new character.
  - clear coinciding with an accept: the digit is flushed.
- Simultaneous push and pop: fifo_level is unchanged. A push into a full FIFO is impossible because ready is low.
- ena low mid-frame: the frame finishes; the FSM then stays in IDLE.

Decomposition:
- Package spigot_pkg: tx_state_t enum (IDLE, START, DATA, STOP); ASCII constants ASCII_ZERO, ASCII_DOT, ASCII_CR, ASCII_LF, ASCII_ERR; digit_t (logic [3:0]).
- Sub-module spigot_digit_fifo:
  - Synchronous FIFO with async active-low reset; ports push/pop/flush/full/empty/level.
  - Read data valid combinationally at the head.
  - Depth FIFO_DEPTH, width 4.

Test Plan:
- CLK_DIV=4, LINE_LEN=4; push digits 3,1,4 -> tx frames 0x33,0x2E,0x31,0x34, each 40 cycles, contiguous; first tx low 2 edges after the first accept; busy falls after the last stop bit.
- Push 3,1,4,1,5,9 -> characters "3.1415\r\n9"; CR LF inserted after the 4th fractional digit; line counter restarts.
- Hold digit_valid=1 with 12 digits while ena=0 -> exactly 8 accepted, digit_ready=0, fifo_level=8, tx stays 1; raise ena -> all drain in order, and ready rises after the first pop.
- Push digit 0xC -> '?' (0x3F) transmitted and err=1 sticky across following digits until rst_n=0.
- Assert clear at cycle 15 of a 0x2E frame with 3 digits queued -> frame completes intact, FIFO flushed, and the next pushed digit 2 yields "2." (first_digit restored).
- Drop rst_n for 1 cycle mid-DATA -> tx=1 immediately (async), fifo_level=0, err=0; normal operation resumes after release.
